tribus_arbiter: RTL



---
 rtl/tribus_arbiter_if.sv | 16 +
 rtl/tribus_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/tribus_arbiter_if.sv
// Request/enable bundle between the tri-state driver bank and the owner arbiter.
// The arbiter takes the master side; drivers and bus consumers take the slave side.
interface tribus_arbiter_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [OW-1:0] owner;
  logic          bus_idle;
  logic          preempt;

  modport master (input req, output grant, output owner, output bus_idle, output preempt);
  modport slave  (output req, input grant, input owner, input bus_idle, input preempt);
endinterface

// File: rtl/tribus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state net: one-hot bufif enables,
// TURN dead cycles between owners and a MAXHOLD tenure limit when others wait.
module tribus_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TURN    = 1,
  parameter int unsigned MAXHOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  tribus_arbiter_if.master   bus
);
  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = OW + 1;
  localparam int unsigned HW = 8;
  localparam int unsigned TW = 3;

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

  state_t        state;
  logic [N-1:0]  grant_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] ptr;
  logic [HW-1:0] hold;
  logic [TW-1:0] tcnt;
  logic          bus_idle_q;
  logic          preempt_q;

  logic [OW-1:0] pick;
  logic [SW-1:0] sum;
  logic          any_req;
  logic          arb_now;
  logic          others_wait;
  logic          hold_max;

  // First requester found scanning ptr, ptr+1, ... wrapping at N.
  always_comb begin
    pick = ptr;
    sum  = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      sum = SW'(ptr) + SW'(i);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      if (bus.req[sum[OW-1:0]]) pick = sum[OW-1:0];
    end
  end

  assign any_req     = |bus.req;
  assign arb_now     = (state == S_IDLE) || ((state == S_TURN) && (tcnt == TW'(TURN - 1)));
  assign others_wait = |(bus.req & ~grant_q);
  assign hold_max    = (hold == HW'(MAXHOLD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr        <= '0;
      hold       <= '0;
      tcnt       <= '0;
      bus_idle_q <= 1'b1;
      preempt_q  <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      if (arb_now) begin
        if (any_req) begin
          state      <= S_OWN;
          grant_q    <= N'(1) << pick;
          owner_q    <= pick;
          hold       <= HW'(1);
          bus_idle_q <= 1'b0;
        end else begin
          state <= S_IDLE;
        end
      end else if (state == S_OWN) begin
        // Owner still requesting at release means the tenure was cut by MAXHOLD.
        if (!bus.req[owner_q] || (hold_max && others_wait)) begin
          state      <= S_TURN;
          grant_q    <= '0;
          bus_idle_q <= 1'b1;
          tcnt       <= '0;
          ptr        <= (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
          preempt_q  <= bus.req[owner_q];
        end else if (!hold_max) begin
          hold <= hold + HW'(1);
        end
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  assign bus.grant    = grant_q;
  assign bus.owner    = owner_q;
  assign bus.bus_idle = bus_idle_q;
  assign bus.preempt  = preempt_q;
endmodule
